intra_mb_scheduler: RTL

//  Frame-level macroblock sequencer for the intra prediction loop (intraloop).
//  - Walks a frame in raster order and drives mbnumber plus a one-cycle mb_start.
//  - Waits for the loop's mb_done before advancing to the next macroblock.
//  - Supplies neighbour-availability flags and frame busy/done status to the encoder top.

---
 rtl/intra_pkg.sv | 15 +
 rtl/intra_mb_scheduler_pos_counter.sv | 85 ++++++++
 rtl/intra_mb_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/intra_pkg.sv
// Shared types and widths for the intra macroblock scheduler.
package intra_pkg;

    localparam int MBNUM_W = 13;
    localparam int MBPOS_W = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/intra_mb_scheduler_pos_counter.sv
// mb_pos_counter: raster-order macroblock position counter.
// Holds mbnumber, column and row, plus the neighbour-availability flags,
// all registered so they change together on the cycle after clear/inc.
// last_mb flags the final macroblock of the frame.
module mb_pos_counter
    import intra_pkg::*;
#(
    parameter int MB_COLS = 120,
    parameter int MB_ROWS = 68
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    output logic [MBNUM_W-1:0] mbnumber,
    output logic [MBPOS_W-1:0] mb_x,
    output logic [MBPOS_W-1:0] mb_y,
    output logic               left_avail,
    output logic               top_avail,
    output logic               topright_avail,
    output logic               last_mb
);

    localparam logic [MBPOS_W-1:0] X_LAST   = MBPOS_W'(MB_COLS - 1);
    localparam logic [MBNUM_W-1:0] NUM_LAST = MBNUM_W'(MB_COLS * MB_ROWS - 1);

    logic [MBNUM_W-1:0] mbnumber_q, mbnumber_d;
    logic [MBPOS_W-1:0] mb_x_q, mb_x_d;
    logic [MBPOS_W-1:0] mb_y_q, mb_y_d;
    logic               left_q, left_d;
    logic               top_q, top_d;
    logic               topright_q, topright_d;

    // Next position: clear wins over inc; the column wraps into the next row.
    always_comb begin
        mbnumber_d = mbnumber_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        if (clear) begin
            mbnumber_d = '0;
            mb_x_d     = '0;
            mb_y_d     = '0;
        end else if (inc) begin
            mbnumber_d = mbnumber_q + MBNUM_W'(1);
            if (mb_x_q == X_LAST) begin
                mb_x_d = '0;
                mb_y_d = mb_y_q + MBPOS_W'(1);
            end else begin
                mb_x_d = mb_x_q + MBPOS_W'(1);
            end
        end
        left_d     = (mb_x_d != '0);
        top_d      = (mb_y_d != '0);
        topright_d = (mb_y_d != '0) && (mb_x_d != X_LAST);
    end

    // Position and availability registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mbnumber_q <= '0;
            mb_x_q     <= '0;
            mb_y_q     <= '0;
            left_q     <= 1'b0;
            top_q      <= 1'b0;
            topright_q <= 1'b0;
        end else begin
            mbnumber_q <= mbnumber_d;
            mb_x_q     <= mb_x_d;
            mb_y_q     <= mb_y_d;
            left_q     <= left_d;
            top_q      <= top_d;
            topright_q <= topright_d;
        end
    end

    assign mbnumber       = mbnumber_q;
    assign mb_x           = mb_x_q;
    assign mb_y           = mb_y_q;
    assign left_avail     = left_q;
    assign top_avail      = top_q;
    assign topright_avail = topright_q;
    assign last_mb        = (mbnumber_q == NUM_LAST);

endmodule

// File: rtl/intra_mb_scheduler.sv
// intra_mb_scheduler: walks a frame in raster order, issuing one mb_start
// per macroblock and waiting for the intra loop's mb_done before moving on.
// Optional feature macro: INTRA_SCHED_WDOG_EN adds a WAIT-state watchdog
// (wdog_err output, WDOG_CYCLES parameter).
//
// Handshake: mb_start is a one-cycle pulse in ISSUE; mb_done is a pulse the
// loop may raise any time from that ISSUE cycle on. It is latched in
// done_seen even while enable=0, so a completion is never lost. WAIT exits
// on the latched flag or on a same-cycle mb_done, which gives two cycles
// from mb_done to the next mb_start (NEXT, ISSUE).
module intra_mb_scheduler
    import intra_pkg::*;
#(
    parameter int MB_COLS = 120,
    parameter int MB_ROWS = 68
`ifdef INTRA_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 4096
`endif
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_start,
    input  logic               mb_done,
    output logic               mb_start,
    output logic [MBNUM_W-1:0] mbnumber,
    output logic [MBPOS_W-1:0] mb_x,
    output logic [MBPOS_W-1:0] mb_y,
    output logic               left_avail,
    output logic               top_avail,
    output logic               topright_avail,
    output logic               frame_busy,
    output logic               frame_done,
    output sched_state_e       dbg_state
`ifdef INTRA_SCHED_WDOG_EN
    ,
    output logic               wdog_err
`endif
);

    sched_state_e state_q, state_d;
    logic         done_seen_q, done_seen_d;
    logic         frame_busy_q, frame_busy_d;
    logic         pos_clear;
    logic         pos_inc;
    logic         last_mb;
    logic         mb_start_c;
    logic         frame_done_c;

`ifdef INTRA_SCHED_WDOG_EN
    localparam int WDOG_W = 13;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
`endif

    mb_pos_counter #(
        .MB_COLS (MB_COLS),
        .MB_ROWS (MB_ROWS)
    ) u_pos (
        .clk            (clk),
        .rst            (reset),
        .clear          (pos_clear),
        .inc            (pos_inc),
        .mbnumber       (mbnumber),
        .mb_x           (mb_x),
        .mb_y           (mb_y),
        .left_avail     (left_avail),
        .top_avail      (top_avail),
        .topright_avail (topright_avail),
        .last_mb        (last_mb)
    );

    // Next-state, pulses and done latch; enable=0 freezes everything but the latch.
    always_comb begin
        state_d      = state_q;
        done_seen_d  = done_seen_q;
        pos_clear    = 1'b0;
        pos_inc      = 1'b0;
        mb_start_c   = 1'b0;
        frame_done_c = 1'b0;
`ifdef INTRA_SCHED_WDOG_EN
        wdog_cnt_d   = wdog_cnt_q;
        wdog_err_d   = 1'b0;
`endif

        if (mb_done && (state_q == ISSUE || state_q == WAIT)) begin
            done_seen_d = 1'b1;
        end

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        pos_clear = 1'b1;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    mb_start_c = 1'b1;
                    state_d    = WAIT;
`ifdef INTRA_SCHED_WDOG_EN
                    wdog_cnt_d = '0;
`endif
                end
                WAIT: begin
                    if (done_seen_q || mb_done) begin
                        done_seen_d = 1'b0;
                        state_d     = NEXT;
`ifdef INTRA_SCHED_WDOG_EN
                    end else if (wdog_cnt_q == WDOG_LAST) begin
                        done_seen_d = 1'b0;
                        wdog_err_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
`endif
                    end
                end
                NEXT: begin
                    if (last_mb) begin
                        state_d = DONE;
                    end else begin
                        pos_inc = 1'b1;
                        state_d = ISSUE;
                    end
                end
                DONE: begin
                    frame_done_c = 1'b1;
                    state_d      = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        frame_busy_d = (state_d != IDLE);
    end

    // State, done latch and busy status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            done_seen_q  <= 1'b0;
            frame_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_seen_q  <= done_seen_d;
            frame_busy_q <= frame_busy_d;
        end
    end

`ifdef INTRA_SCHED_WDOG_EN
    // Watchdog counter and its error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`endif

    assign mb_start   = mb_start_c;
    assign frame_done = frame_done_c;
    assign frame_busy = frame_busy_q;
    assign dbg_state  = state_q;

endmodule
